// File: rtl/pkt_router.sv
// Two-stage packet router: a lookup stage holds the accepted packet, an output
// stage presents it on the channel chosen by the first matching table entry.
module pkt_router #(
    parameter int NUM_RREGS    = 16,
    parameter int NUM_CHANNELS = 8,
    parameter int PKT_BITS     = 72
) (
    input  logic                             clk_tb,
    input  logic                             reset_tb,
    input  logic [31:0]                      drop_wait_in,
    input  logic [NUM_RREGS*32-1:0]          reg_key_in,
    input  logic [NUM_RREGS*32-1:0]          reg_mask_in,
    input  logic [NUM_RREGS*3-1:0]           reg_route_in,
    input  logic [PKT_BITS-1:0]              pkt_in_data_in,
    input  logic                             pkt_in_vld_in,
    output logic                             pkt_in_rdy_out,
    output logic [NUM_CHANNELS*PKT_BITS-1:0] pkt_out_data_out,
    output logic [NUM_CHANNELS-1:0]          pkt_out_vld_out,
    input  logic [NUM_CHANNELS-1:0]          pkt_out_rdy_in,
    output logic [1:0]                       rt_cnt_out
);

    localparam int         KEY_LSB     = 8;
    localparam logic [3:0] NUM_CH_WIDE = 4'(NUM_CHANNELS);

    logic                l_valid;
    logic [PKT_BITS-1:0] l_pkt;
    logic                o_valid;
    logic [PKT_BITS-1:0] o_pkt;
    logic [2:0]          o_chan;
    logic [31:0]         wait_cnt;

    logic [31:0] l_key;
    logic        hit;
    logic [2:0]  route;
    logic        route_ok;
    logic [7:0]  rdy_ext;
    logic        o_rdy;
    logic        o_xfer;
    logic        o_drop;
    logic        o_free;
    logic        l_adv;
    logic        l_load;
    logic        l_discard;
    logic        in_xfer;

    assign l_key = l_pkt[KEY_LSB+31:KEY_LSB];

    // Scanning from the top index down lets the lowest matching entry win.
    always_comb begin
        hit   = 1'b0;
        route = 3'd0;
        for (int i = NUM_RREGS - 1; i >= 0; i--) begin
            if ((l_key & reg_mask_in[i*32 +: 32]) == reg_key_in[i*32 +: 32]) begin
                hit   = 1'b1;
                route = reg_route_in[i*3 +: 3];
            end
        end
    end

    assign route_ok = hit && ({1'b0, route} < NUM_CH_WIDE);

    assign rdy_ext = 8'(pkt_out_rdy_in);
    assign o_rdy   = rdy_ext[o_chan];
    assign o_xfer  = o_valid && o_rdy;
    // Greater-or-equal keeps a live decrease of drop_wait_in from wedging a channel.
    assign o_drop  = o_valid && !o_rdy && (wait_cnt >= drop_wait_in);
    assign o_free  = !o_valid || o_xfer || o_drop;

    assign l_adv     = l_valid && o_free;
    assign l_load    = l_adv && route_ok;
    assign l_discard = l_adv && !route_ok;

    assign pkt_in_rdy_out = !reset_tb && (!l_valid || l_adv);
    assign in_xfer        = pkt_in_vld_in && pkt_in_rdy_out;

    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            l_valid <= 1'b0;
            l_pkt   <= '0;
        end else if (in_xfer) begin
            l_valid <= 1'b1;
            l_pkt   <= pkt_in_data_in;
        end else if (l_adv) begin
            l_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            o_valid  <= 1'b0;
            o_pkt    <= '0;
            o_chan   <= 3'd0;
            wait_cnt <= 32'd0;
        end else if (l_load) begin
            o_valid  <= 1'b1;
            o_pkt    <= l_pkt;
            o_chan   <= route;
            wait_cnt <= 32'd0;
        end else if (o_xfer || o_drop) begin
            o_valid <= 1'b0;
        end else if (o_valid) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end

    always_comb begin
        pkt_out_vld_out = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            pkt_out_vld_out[c] = o_valid && (o_chan == 3'(c));
        end
    end

    assign pkt_out_data_out = {NUM_CHANNELS{o_pkt}};
    assign rt_cnt_out       = {l_discard || o_drop, o_xfer};

endmodule

// File: tb/tb_pkt_router.sv
// Directed bench for pkt_router: a scoreboard queue of expected deliveries is
// filled on input acceptance and drained as packets appear on the channels.
module tb_pkt_router;

    localparam int NR  = 16;
    localparam int NC  = 8;
    localparam int PB  = 72;

    typedef struct packed {
        logic [2:0]    ch;
        logic [PB-1:0] data;
        logic [31:0]   cyc;
    } exp_t;

    logic            clk_tb;
    logic            reset_tb;
    logic [31:0]     drop_wait_in;
    logic [NR*32-1:0] key_flat;
    logic [NR*32-1:0] mask_flat;
    logic [NR*3-1:0]  route_flat;
    logic [PB-1:0]   pkt_in_data_in;
    logic            pkt_in_vld_in;
    logic            pkt_in_rdy_out;
    logic [NC*PB-1:0] pkt_out_data_out;
    logic [NC-1:0]   pkt_out_vld_out;
    logic [NC-1:0]   pkt_out_rdy_in;
    logic [1:0]      rt_cnt_out;

    logic [31:0] t_key   [NR];
    logic [31:0] t_mask  [NR];
    logic [2:0]  t_route [NR];

    exp_t        sb[$];
    int          errors;
    int          checks;
    int          cyc;
    int          exp_drop;
    int          obs_drop;
    int          stalls;
    logic [31:0] seq;
    bit          mon_en;
    bit          lat_en;

    logic [NC-1:0] s_vld;
    logic [1:0]    s_rt;
    logic          s_in_rdy;
    logic [PB-1:0] s_data;
    logic          s_data_zero;

    pkt_router #(.NUM_RREGS(NR), .NUM_CHANNELS(NC), .PKT_BITS(PB)) dut (
        .clk_tb          (clk_tb),
        .reset_tb        (reset_tb),
        .drop_wait_in    (drop_wait_in),
        .reg_key_in      (key_flat),
        .reg_mask_in     (mask_flat),
        .reg_route_in    (route_flat),
        .pkt_in_data_in  (pkt_in_data_in),
        .pkt_in_vld_in   (pkt_in_vld_in),
        .pkt_in_rdy_out  (pkt_in_rdy_out),
        .pkt_out_data_out(pkt_out_data_out),
        .pkt_out_vld_out (pkt_out_vld_out),
        .pkt_out_rdy_in  (pkt_out_rdy_in),
        .rt_cnt_out      (rt_cnt_out)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    always_comb begin
        key_flat   = '0;
        mask_flat  = '0;
        route_flat = '0;
        for (int i = 0; i < NR; i++) begin
            key_flat[i*32 +: 32]  = t_key[i];
            mask_flat[i*32 +: 32] = t_mask[i];
            route_flat[i*3 +: 3]  = t_route[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First matching entry wins; an empty result means the packet is discarded.
    function automatic logic [3:0] modelRoute(input logic [31:0] key);
        for (int i = 0; i < NR; i++) begin
            if ((key & t_mask[i]) == t_key[i]) return {1'b1, t_route[i]};
        end
        return 4'b0000;
    endfunction

    task automatic monitor();
        logic [3:0] r;
        bit         delivered;
        logic [2:0] dch;
        exp_t       e;
        if (pkt_in_vld_in && s_in_rdy) begin
            r = modelRoute(pkt_in_data_in[39:8]);
            if (r[3]) sb.push_back('{ch: r[2:0], data: pkt_in_data_in, cyc: 32'(cyc)});
            else exp_drop++;
        end
        delivered = 1'b0;
        dch = 3'd0;
        for (int c = 0; c < NC; c++) begin
            if (s_vld[c] && pkt_out_rdy_in[c]) begin
                delivered = 1'b1;
                dch = 3'(c);
            end
        end
        checkOutput("vld_onehot", 72'($countones(s_vld) <= 1), 72'd1);
        checkOutput("route_pulse", 72'(s_rt[0]), 72'(delivered));
        if (delivered) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 72'd1, 72'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("out_channel", 72'(dch), 72'(e.ch));
                checkOutput("out_data", s_data, e.data);
                if (lat_en) checkOutput("latency", 72'(cyc), 72'(e.cyc + 32'd2));
            end
        end
        if (s_rt[1]) obs_drop++;
    endtask

    task automatic tick();
        @(negedge clk_tb);
        s_vld       = pkt_out_vld_out;
        s_rt        = rt_cnt_out;
        s_in_rdy    = pkt_in_rdy_out;
        s_data      = pkt_out_data_out[PB-1:0];
        s_data_zero = (pkt_out_data_out == '0);
        if (mon_en) monitor();
        @(posedge clk_tb);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input int first, input int n, input bit toggle, input bit scramble);
        int k;
        int guard;
        k = first;
        guard = 0;
        while (k < first + n && guard < n * 4 + 20) begin
            if (toggle) pkt_out_rdy_in = (cyc % 2 == 1) ? 8'hFF : 8'h00;
            pkt_in_vld_in  = 1'b1;
            pkt_in_data_in = {seq, (scramble ? 32'(k) * 32'h9E3779B1 : 32'(k)), 8'h5A};
            tick();
            if (s_in_rdy) begin
                k++;
                seq++;
            end else begin
                stalls++;
            end
            guard++;
        end
        pkt_in_vld_in = 1'b0;
        checkOutput("stream_done", 72'(k), 72'(first + n));
        repeat (8) begin
            if (toggle) pkt_out_rdy_in = (cyc % 2 == 1) ? 8'hFF : 8'h00;
            tick();
        end
    endtask

    task automatic endTest(input string name);
        checkOutput({name, "_sb_empty"}, 72'(sb.size()), 72'd0);
        checkOutput({name, "_drops"}, 72'(obs_drop), 72'(exp_drop));
        sb.delete();
        exp_drop = 0;
        obs_drop = 0;
        stalls   = 0;
    endtask

    initial begin
        int         hi3;
        int         drops;
        int         drop_at;
        bit         seen5;
        bit         five_after_drop;
        logic [PB-1:0] pa;
        logic [PB-1:0] pb;
        logic [PB-1:0] d5;

        errors = 0; checks = 0; cyc = 0; exp_drop = 0; obs_drop = 0; stalls = 0;
        seq = 32'd0; mon_en = 1'b0; lat_en = 1'b1;
        reset_tb = 1'b1;
        drop_wait_in = 32'd4;
        pkt_in_vld_in = 1'b0;
        pkt_in_data_in = '0;
        pkt_out_rdy_in = '1;
        for (int i = 0; i < NR; i++) begin
            t_key[i]   = 32'(i);
            t_mask[i]  = 32'h1F;
            t_route[i] = 3'(i);
        end

        repeat (2) tick();
        checkOutput("reset_in_rdy", 72'(s_in_rdy), 72'd0);
        checkOutput("reset_vld", 72'(s_vld), 72'd0);
        checkOutput("reset_rt", 72'(s_rt), 72'd0);
        checkOutput("reset_data", 72'(s_data_zero), 72'd1);
        reset_tb = 1'b0;
        tick();
        checkOutput("post_reset_in_rdy", 72'(s_in_rdy), 72'd1);

        // Matching keys, every channel ready
        mon_en = 1'b1;
        applyStimulus(0, 16, 1'b0, 1'b0);
        checkOutput("match_stalls", 72'(stalls), 72'd0);
        endTest("match");

        // Unmatched keys are discarded without stalling input
        applyStimulus(16, 16, 1'b0, 1'b0);
        checkOutput("nomatch_stalls", 72'(stalls), 72'd0);
        endTest("nomatch");

        // Blocked channel 3 times out, then the queued key 5 follows
        mon_en = 1'b0;
        pkt_out_rdy_in = 8'hF7;
        pa = {32'hAAAA0000, 32'd3, 8'h11};
        pb = {32'hBBBB0000, 32'd5, 8'h22};
        hi3 = 0; drops = 0; drop_at = 0; seen5 = 1'b0; five_after_drop = 1'b0; d5 = '0;
        for (int t = 0; t < 30; t++) begin
            pkt_in_vld_in  = (t < 2);
            pkt_in_data_in = (t == 0) ? pa : pb;
            tick();
            if (s_vld[3]) hi3++;
            if (s_rt[1]) begin
                drops++;
                drop_at = hi3;
            end
            if (s_vld[5] && !seen5) begin
                seen5 = 1'b1;
                d5 = s_data;
                five_after_drop = (drops == 1);
            end
        end
        pkt_in_vld_in = 1'b0;
        checkOutput("timeout_vld_cycles", 72'(hi3), 72'd5);
        checkOutput("timeout_drops", 72'(drops), 72'd1);
        checkOutput("timeout_drop_at", 72'(drop_at), 72'd5);
        checkOutput("timeout_next_loaded", 72'(five_after_drop), 72'd1);
        checkOutput("timeout_next_data", d5, pb);
        pkt_out_rdy_in = '1;

        // Ready toggling every cycle never reaches the drop limit
        mon_en = 1'b1;
        lat_en = 1'b0;
        applyStimulus(0, 16, 1'b1, 1'b0);
        pkt_out_rdy_in = '1;
        endTest("toggle");
        lat_en = 1'b1;

        // All-zero table: entry 0 catches everything and routes to channel 0
        for (int i = 0; i < NR; i++) begin
            t_key[i]   = 32'd0;
            t_mask[i]  = 32'd0;
            t_route[i] = 3'(i);
        end
        applyStimulus(1, 12, 1'b0, 1'b1);
        endTest("zero_table");

        // Reset asserted while packets are in flight
        for (int i = 0; i < NR; i++) begin
            t_key[i]   = 32'(i);
            t_mask[i]  = 32'h1F;
            t_route[i] = 3'(i);
        end
        for (int k = 0; k < 5; k++) begin
            pkt_in_vld_in  = 1'b1;
            pkt_in_data_in = {seq, 32'(k), 8'h5A};
            tick();
            seq++;
        end
        pkt_in_vld_in = 1'b0;
        reset_tb = 1'b1;
        #1;
        checkOutput("midreset_vld", 72'(pkt_out_vld_out), 72'd0);
        checkOutput("midreset_rt", 72'(rt_cnt_out), 72'd0);
        checkOutput("midreset_in_rdy", 72'(pkt_in_rdy_out), 72'd0);
        mon_en = 1'b0;
        sb.delete();
        exp_drop = 0;
        obs_drop = 0;
        tick();
        tick();
        reset_tb = 1'b0;
        tick();
        checkOutput("midreset_release_rdy", 72'(s_in_rdy), 72'd1);
        mon_en = 1'b1;
        applyStimulus(8, 8, 1'b0, 1'b0);
        endTest("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
